// File: rtl/audio_port_pkg.sv
// Shared types and constants for the codec audio sample port.
package audio_port_pkg;

  localparam int unsigned SAMPLE_W = 24;

  typedef logic [SAMPLE_W-1:0] sample_t;

  typedef enum logic [1:0] {
    RX_SYNC,
    RX_DELAY,
    RX_SHIFT,
    RX_SKIP
  } rx_state_t;

  typedef enum logic [1:0] {
    TX_IDLE,
    TX_SHIFT,
    TX_PAD
  } tx_state_t;

endpackage

// File: rtl/sample_fifo.sv
// Show-ahead FIFO with pointer+count bookkeeping; push and pop in the same
// cycle are both honoured, including when full.
module sample_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 24
) (
  input  logic             CLOCK_50,
  input  logic             reset,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_head,
  output logic             o_empty,
  output logic             o_full
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_rd;
  logic [AW-1:0]    r_wr;
  logic [CW-1:0]    r_cnt;

  logic w_empty;
  logic w_full;
  logic w_do_pop;
  logic w_do_push;

  assign w_empty   = (r_cnt == '0);
  assign w_full    = (r_cnt == CW'(DEPTH));
  assign w_do_pop  = i_pop & ~w_empty;
  // A full FIFO still accepts a push when the head leaves in the same cycle.
  assign w_do_push = i_push & (~w_full | w_do_pop);

  // Storage, pointers and occupancy count.
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        r_mem[i] <= '0;
      end
      r_rd  <= '0;
      r_wr  <= '0;
      r_cnt <= '0;
    end else begin
      if (w_do_push) begin
        r_mem[r_wr] <= i_data;
        r_wr        <= r_wr + AW'(1);
      end
      if (w_do_pop) begin
        r_rd <= r_rd + AW'(1);
      end
      case ({w_do_push, w_do_pop})
        2'b10:   r_cnt <= r_cnt + CW'(1);
        2'b01:   r_cnt <= r_cnt - CW'(1);
        default: r_cnt <= r_cnt;
      endcase
    end
  end

  assign o_head  = r_mem[r_rd];
  assign o_empty = w_empty;
  assign o_full  = w_full;

endmodule

// File: rtl/audio_sample_port.sv
// Codec-side I2S sample port: ADC left slot into an RX FIFO, TX FIFO out to
// the DAC line duplicated into both slots. The codec is clock master; all
// pins are synchronized into CLOCK_50.
// Build option: define DAC_HOLD_LAST_EN to repeat the last sample on
// underflow instead of sending zeros.
module audio_sample_port
  import audio_port_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic    CLOCK_50,
  input  logic    reset,
  input  logic    AUD_BCLK,
  input  logic    AUD_ADCLRCK,
  input  logic    AUD_ADCDAT,
  input  logic    AUD_DACLRCK,
  output logic    AUD_DACDAT,
  output logic    read_ready,
  input  logic    read,
  output sample_t readdata,
  output logic    write_ready,
  input  logic    write,
  input  sample_t writedata,
  output logic    adc_overflow,
  output logic    dac_underflow
);

  localparam int unsigned CNT_W = $clog2(SAMPLE_W + 1);
  localparam int unsigned NSYNC = 4;

  // Synchronizer bit order: {DACLRCK, ADCDAT, ADCLRCK, BCLK}
  logic [NSYNC-1:0] r_meta;
  logic [NSYNC-1:0] r_sync;
  logic [2:0]       r_prev;   // {DACLRCK, ADCLRCK, BCLK}

  logic w_bclk_rise;
  logic w_bclk_fall;
  logic w_adclrck_fall;
  logic w_daclrck_fall;
  logic w_daclrck_rise;
  logic w_adcdat;

  // Two-flop synchronizers plus previous-value register for edge detection.
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      r_meta <= '0;
      r_sync <= '0;
      r_prev <= '0;
    end else begin
      r_meta <= {AUD_DACLRCK, AUD_ADCDAT, AUD_ADCLRCK, AUD_BCLK};
      r_sync <= r_meta;
      r_prev <= {r_sync[3], r_sync[1], r_sync[0]};
    end
  end

  assign w_bclk_rise    =  r_sync[0] & ~r_prev[0];
  assign w_bclk_fall    = ~r_sync[0] &  r_prev[0];
  assign w_adclrck_fall = ~r_sync[1] &  r_prev[1];
  assign w_adcdat       =  r_sync[2];
  assign w_daclrck_fall = ~r_sync[3] &  r_prev[2];
  assign w_daclrck_rise =  r_sync[3] & ~r_prev[2];

  // ---------------------------------------------------------------- RX path
  rx_state_t        r_rx_state;
  rx_state_t        w_rx_state_nxt;
  sample_t          r_rx_shift;
  sample_t          w_rx_shift_nxt;
  logic [CNT_W-1:0] r_rx_cnt;
  logic [CNT_W-1:0] w_rx_cnt_nxt;
  logic             r_rx_push;
  logic             w_rx_push_nxt;

  logic             w_rx_empty;
  logic             w_rx_full;
  sample_t          w_rx_head;
  logic             r_adc_overflow;

  // RX state and deserializer registers.
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      r_rx_state <= RX_SYNC;
      r_rx_shift <= '0;
      r_rx_cnt   <= '0;
      r_rx_push  <= 1'b0;
    end else begin
      r_rx_state <= w_rx_state_nxt;
      r_rx_shift <= w_rx_shift_nxt;
      r_rx_cnt   <= w_rx_cnt_nxt;
      r_rx_push  <= w_rx_push_nxt;
    end
  end

  // RX next-state: align to a left-slot start, skip the delay bit, take SAMPLE_W bits.
  always_comb begin
    w_rx_state_nxt = r_rx_state;
    w_rx_shift_nxt = r_rx_shift;
    w_rx_cnt_nxt   = r_rx_cnt;
    w_rx_push_nxt  = 1'b0;
    case (r_rx_state)
      RX_SYNC: begin
        if (w_adclrck_fall) w_rx_state_nxt = RX_DELAY;
      end
      RX_DELAY: begin
        if (w_bclk_rise) begin
          w_rx_state_nxt = RX_SHIFT;
          w_rx_cnt_nxt   = '0;
        end
      end
      RX_SHIFT: begin
        if (w_adclrck_fall) begin
          // Slot ended early: drop the fragment and restart on this frame.
          w_rx_state_nxt = RX_DELAY;
        end else if (w_bclk_rise) begin
          w_rx_shift_nxt = {r_rx_shift[SAMPLE_W-2:0], w_adcdat};
          w_rx_cnt_nxt   = r_rx_cnt + CNT_W'(1);
          if (r_rx_cnt == CNT_W'(SAMPLE_W - 1)) begin
            w_rx_state_nxt = RX_SKIP;
            w_rx_push_nxt  = 1'b1;
          end
        end
      end
      RX_SKIP: begin
        if (w_adclrck_fall) w_rx_state_nxt = RX_DELAY;
      end
      default: w_rx_state_nxt = RX_SYNC;
    endcase
  end

  sample_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (SAMPLE_W)
  ) u_rx_fifo (
    .CLOCK_50 (CLOCK_50),
    .reset    (reset),
    .i_push   (r_rx_push),
    .i_data   (r_rx_shift),
    .i_pop    (read),
    .o_head   (w_rx_head),
    .o_empty  (w_rx_empty),
    .o_full   (w_rx_full)
  );

  // Sticky flag for a completed ADC word that found no room.
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      r_adc_overflow <= 1'b0;
    end else if (r_rx_push && w_rx_full && !read) begin
      r_adc_overflow <= 1'b1;
    end
  end

  // ---------------------------------------------------------------- TX path
  tx_state_t        r_tx_state;
  tx_state_t        w_tx_state_nxt;
  sample_t          r_tx_word;
  sample_t          w_tx_word_nxt;
  sample_t          r_tx_shift;
  sample_t          w_tx_shift_nxt;
  logic [CNT_W-1:0] r_tx_cnt;
  logic [CNT_W-1:0] w_tx_cnt_nxt;
  logic             r_dacdat;
  logic             w_dacdat_nxt;
  logic             w_tx_pop;
  logic             w_unf_set;

  logic             w_tx_empty;
  logic             w_tx_full;
  sample_t          w_tx_head;
  logic             r_dac_underflow;

  sample_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (SAMPLE_W)
  ) u_tx_fifo (
    .CLOCK_50 (CLOCK_50),
    .reset    (reset),
    .i_push   (write),
    .i_data   (writedata),
    .i_pop    (w_tx_pop),
    .o_head   (w_tx_head),
    .o_empty  (w_tx_empty),
    .o_full   (w_tx_full)
  );

  // TX state, held word, serializer and the registered DAC pin.
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      r_tx_state <= TX_IDLE;
      r_tx_word  <= '0;
      r_tx_shift <= '0;
      r_tx_cnt   <= '0;
      r_dacdat   <= 1'b0;
    end else begin
      r_tx_state <= w_tx_state_nxt;
      r_tx_word  <= w_tx_word_nxt;
      r_tx_shift <= w_tx_shift_nxt;
      r_tx_cnt   <= w_tx_cnt_nxt;
      r_dacdat   <= w_dacdat_nxt;
    end
  end

  // TX next-state: load on each LRCK edge, emit MSB-first on BCLK falls, then pad.
  always_comb begin
    w_tx_state_nxt = r_tx_state;
    w_tx_word_nxt  = r_tx_word;
    w_tx_shift_nxt = r_tx_shift;
    w_tx_cnt_nxt   = r_tx_cnt;
    w_dacdat_nxt   = r_dacdat;
    w_tx_pop       = 1'b0;
    w_unf_set      = 1'b0;
    if (w_daclrck_fall) begin
      if (!w_tx_empty) begin
        w_tx_pop      = 1'b1;
        w_tx_word_nxt = w_tx_head;
      end else begin
        w_unf_set     = 1'b1;
`ifdef DAC_HOLD_LAST_EN
        w_tx_word_nxt = r_tx_word;
`else
        w_tx_word_nxt = '0;
`endif
      end
      w_tx_shift_nxt = w_tx_word_nxt;
      w_tx_cnt_nxt   = '0;
      w_dacdat_nxt   = 1'b0;
      w_tx_state_nxt = TX_SHIFT;
    end else if (w_daclrck_rise && (r_tx_state != TX_IDLE)) begin
      // Right slot repeats the left-slot word.
      w_tx_shift_nxt = r_tx_word;
      w_tx_cnt_nxt   = '0;
      w_dacdat_nxt   = 1'b0;
      w_tx_state_nxt = TX_SHIFT;
    end else if (w_bclk_fall) begin
      case (r_tx_state)
        TX_SHIFT: begin
          w_dacdat_nxt   = r_tx_shift[SAMPLE_W-1];
          w_tx_shift_nxt = {r_tx_shift[SAMPLE_W-2:0], 1'b0};
          w_tx_cnt_nxt   = r_tx_cnt + CNT_W'(1);
          if (r_tx_cnt == CNT_W'(SAMPLE_W - 1)) w_tx_state_nxt = TX_PAD;
        end
        TX_PAD:  w_dacdat_nxt = 1'b0;
        default: w_dacdat_nxt = 1'b0;
      endcase
    end
  end

  // Sticky flag for a frame that started with nothing queued.
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      r_dac_underflow <= 1'b0;
    end else if (w_unf_set) begin
      r_dac_underflow <= 1'b1;
    end
  end

  assign read_ready    = ~w_rx_empty;
  assign readdata      = w_rx_head;
  assign write_ready   = ~w_tx_full;
  assign AUD_DACDAT    = r_dacdat;
  assign adc_overflow  = r_adc_overflow;
  assign dac_underflow = r_dac_underflow;

endmodule

// File: doc/audio_sample_port.md
Name: audio_sample_port

Overview:
- Codec-side responder for the running-mean filter's sample handshake.
- Deserializes I2S ADC data (left slot) into a receive FIFO and presents it on read_ready/read/readdata.
- Accepts filtered samples on write_ready/write/writedata into a transmit FIFO and serializes them onto the DAC line, mono-duplicated into both slots.
- Codec is clock master; all logic runs on CLOCK_50.

Parameters:
SAMPLE_W, 24, audio sample width in bits
DEPTH, 4, entries per FIFO (power of two, >=2)

Ports:
CLOCK_50  in  1  system clock, 50 MHz
reset  in  1  synchronous, active-high
AUD_BCLK  in  1  codec bit clock (asynchronous)
AUD_ADCLRCK  in  1  ADC word select; low = left slot
AUD_ADCDAT  in  1  ADC serial data
AUD_DACLRCK  in  1  DAC word select; low = left slot
AUD_DACDAT  out  1  DAC serial data
read_ready  out  1  RX FIFO non-empty
read  in  1  pop RX head
readdata  out  SAMPLE_W  RX FIFO head (show-ahead)
write_ready  out  1  TX FIFO not full
write  in  1  push writedata
writedata  in  SAMPLE_W  sample to transmit
adc_overflow  out  1  sticky: ADC sample dropped
dac_underflow  out  1  sticky: frame started with TX FIFO empty

Behaviour:
- Reset:
  - reset is synchronous, active-high; clock is CLOCK_50.
  - Clears both FIFOs, all counters and shift registers, and both flags.
  - Outputs after reset: read_ready=0, write_ready=1, readdata=0, AUD_DACDAT=0.
- Synchronizers and edge detect:
  - BCLK, both LRCKs and ADCDAT pass through 2-FF synchronizers, then edge detection.
  - Edge pulses are one CLOCK_50 cycle wide and occur 3 cycles after the pin edge.
- RX FSM, states RX_SYNC, RX_DELAY, RX_SHIFT, RX_SKIP:
  - RX_SYNC: waits for an ADCLRCK falling edge; no partial frame is ever captured, including after reset.
  - RX_DELAY: consumes the first BCLK rise (I2S delay slot).
  - RX_SHIFT: samples ADCDAT MSB-first on each BCLK rise, SAMPLE_W bits.
  - RX_SKIP: ignores the remaining bits and the right slot; a falling ADCLRCK returns to RX_DELAY.
  - Completed word is pushed into the RX FIFO on the cycle after the last bit.
- RX FIFO:
  - read_ready = not empty; readdata = head, valid whenever read_ready=1.
  - read while empty is ignored.
  - Push while full: if read is also asserted that cycle, both proceed. Otherwise the new word is dropped, contents stay unchanged, and adc_overflow is set.
- TX FIFO:
  - write_ready = not full; write while full is ignored (no flag).
  - Simultaneous pop and push are both honoured.
- TX FSM, states TX_IDLE, TX_SHIFT, TX_PAD:
  - On a DACLRCK falling edge, pop the head into the shift register.
  - If the TX FIFO is empty at that edge, load 0 and set dac_underflow.
  - On a DACLRCK rising edge, reload the same word (mono duplicate).
  - From the first BCLK fall after either LRCK edge, drive the MSB, then shift on each BCLK fall for SAMPLE_W bits.
  - TX_PAD drives 0 until the next LRCK edge.
- AUD_DACDAT is registered; updates 1 cycle after the synchronized fall pulse.
- Flags are sticky until reset.
- Latency, last ADC bit at pin to read_ready high: 4 CLOCK_50 cycles.

Optional Feature:
- Macro: DAC_HOLD_LAST_EN.
- Defined: on underflow, the TX shift register reloads the last transmitted sample instead of 0; dac_underflow is still set.
- Undefined: underflow transmits 0.

Decomposition:
- Package audio_port_pkg holds:
  - SAMPLE_W constant and sample_t typedef (logic [SAMPLE_W-1:0]).
  - rx_state_t and tx_state_t enums.
- Sub-module sample_fifo (DEPTH, WIDTH): show-ahead, pointer+count, simultaneous push/pop. Instantiated twice, for RX and TX.

Test Plan:
- Reset, then one I2S frame with left=24'h000064 and right=24'hFFFFFF -> read_ready rises; readdata=24'h000064; pulsing read clears read_ready.
- Reset asserted mid-left-slot, released mid-slot -> that partial word is discarded; the next full frame left=24'h0000C8 is the only entry.
- 5 frames (100, 200, 300, 400, 500) with no reads, DEPTH=4 -> FIFO holds 100..400; adc_overflow=1; 500 never appears.
- Write 24'hABCDEF -> AUD_DACDAT carries A B C D E F MSB-first after 1-bit delay, in both left and right slots; next frame with no write -> zeros and dac_underflow=1.
- Same underflow with DAC_HOLD_LAST_EN defined -> frame repeats 24'hABCDEF; dac_underflow=1.
- RX FIFO full with read and push in the same cycle -> count stays 4, oldest popped, new word appended, adc_overflow stays 0.
